// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with redirect, debug halt/step and advance counter
module pc_gen #(
  parameter int                XLEN          = 32,
  parameter int                STEP          = 4,
  parameter logic [XLEN-1:0]   RESET_VECTOR  = '0,
  parameter int                HALT_ON_RESET = 0,
  parameter int                CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             step_req,
  input  logic             dbg_pc_we,
  input  logic [XLEN-1:0]  dbg_pc_wdata,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus_step,
  output logic             fetch_valid,
  output logic             halted,
  output logic             misalign,
  output logic [XLEN-1:0]  misalign_addr,
  output logic [CNT_W-1:0] adv_count
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_STEP   = 2'd2
  } state_t;

  localparam state_t RESET_STATE = (HALT_ON_RESET != 0) ? S_HALTED : S_RUN;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  maddr_q, maddr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             advance;
  logic             target_aligned;

  assign pc_plus_step   = pc_q + XLEN'(STEP);
  assign advance        = (state_q != S_HALTED) && !stall;
  assign target_aligned = (redirect_target[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      pc_q    <= RESET_VECTOR;
      maddr_q <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      maddr_q <= maddr_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    maddr_d = maddr_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;

    // A misaligned redirect is dropped: fetch continues sequentially and the target is logged.
    if (advance) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (redirect_valid && target_aligned) begin
        pc_d = redirect_target;
      end else begin
        pc_d = pc_plus_step;
        if (redirect_valid) begin
          mis_d   = 1'b1;
          maddr_d = redirect_target;
        end
      end
    end

    case (state_q)
      S_RUN: begin
        if (advance && halt_req) state_d = S_HALTED;
      end
      S_STEP: begin
        if (advance) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (dbg_pc_we) pc_d = dbg_pc_wdata & ~XLEN'(3);
        if (step_req) begin
          state_d = S_STEP;
        end else if (resume_req && !halt_req) begin
          state_d = S_RUN;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  assign pc            = pc_q;
  assign fetch_valid   = advance;
  assign halted        = (state_q == S_HALTED);
  assign misalign      = mis_q;
  assign misalign_addr = maddr_q;
  assign adv_count     = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed bench for pc_gen with an in-bench reference model
module tb_pc_gen;
  localparam int          XLEN = 32;
  localparam int          CW   = 4;
  localparam logic [31:0] RV   = 32'h80;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stall, redirect_valid, halt_req, resume_req, step_req, dbg_pc_we;
  logic [31:0]     redirect_target, dbg_pc_wdata;
  logic [31:0]     pc, pc_plus_step, misalign_addr;
  logic            fetch_valid, halted, misalign;
  logic [CW-1:0]   adv_count;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  pc_gen #(
    .XLEN(XLEN), .STEP(4), .RESET_VECTOR(RV), .HALT_ON_RESET(0), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .dbg_pc_we(dbg_pc_we), .dbg_pc_wdata(dbg_pc_wdata),
    .pc(pc), .pc_plus_step(pc_plus_step), .fetch_valid(fetch_valid),
    .halted(halted), .misalign(misalign), .misalign_addr(misalign_addr),
    .adv_count(adv_count)
  );

  always #5 clk = ~clk;

  // Reference model: mode is one of "run", "halt", "step"
  string       m_mode = "run";
  logic [31:0] m_pc = RV;
  logic [31:0] m_addr = 32'h0;
  int          m_cnt = 0;
  bit          m_mis = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = "run";
      m_pc   = RV;
      m_addr = 32'h0;
      m_cnt  = 0;
      m_mis  = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (m_mode == "halt") begin
        if (dbg_pc_we) m_pc = (dbg_pc_wdata / 4) * 4;
        if (step_req) m_mode = "step";
        else if (resume_req && !halt_req) m_mode = "run";
      end else if (!stall) begin
        if (redirect_valid && (redirect_target % 4 == 0)) begin
          m_pc = redirect_target;
        end else begin
          m_pc = m_pc + 32'd4;
          if (redirect_valid) begin
            m_mis  = 1'b1;
            m_addr = redirect_target;
          end
        end
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (m_mode == "step" || halt_req) m_mode = "halt";
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("pc_plus_step", pc_plus_step, m_pc + 32'd4);
      chk("halted", 32'(halted), 32'(m_mode == "halt"));
      chk("fetch_valid", 32'(fetch_valid), 32'((m_mode != "halt") && !stall));
      chk("misalign", 32'(misalign), 32'(m_mis));
      chk("misalign_addr", misalign_addr, m_addr);
      chk("adv_count", 32'(adv_count), 32'(m_cnt));
    end
  end

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; redirect_valid = 0; redirect_target = 0; halt_req = 0;
    resume_req = 0; step_req = 0; dbg_pc_we = 0; dbg_pc_wdata = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    next(); next();
    chk("rst_pc", pc, 32'h80);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cnt", 32'(adv_count), 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);
    chk("rst_maddr", misalign_addr, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    next(); next(); next();
    chk("run3_pc", pc, 32'h8C);
    chk("run3_cnt", 32'(adv_count), 32'd3);
    chk("run3_halted", 32'(halted), 32'd0);

    redirect_valid = 1; redirect_target = 32'h100; next();
    chk("redir100", pc, 32'h100);
    redirect_target = 32'h200; next();
    chk("redir200", pc, 32'h200);
    redirect_target = 32'h202; next();
    chk("misal_pc", pc, 32'h204);
    chk("misal_pulse", 32'(misalign), 32'd1);
    chk("misal_addr", misalign_addr, 32'h202);
    redirect_valid = 0; next();
    chk("misal_drop", 32'(misalign), 32'd0);
    chk("misal_hold", misalign_addr, 32'h202);

    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC; next();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    redirect_valid = 0; next();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_cnt9", 32'(adv_count), 32'd9);
    repeat (6) next();
    chk("cnt_max", 32'(adv_count), 32'd15);
    next();
    chk("cnt_wrap", 32'(adv_count), 32'd0);
    chk("pc_1c", pc, 32'h1C);

    stall = 1; halt_req = 1; redirect_valid = 1; redirect_target = 32'h400;
    for (int i = 0; i < 3; i++) begin
      next();
      chk("stall_pc", pc, 32'h1C);
      chk("stall_halted", 32'(halted), 32'd0);
    end
    stall = 0; next();
    chk("unstall_pc", pc, 32'h400);
    chk("unstall_halted", 32'(halted), 32'd1);
    chk("unstall_cnt", 32'(adv_count), 32'd1);
    halt_req = 0; redirect_target = 32'h800; next();
    chk("halt_hold_pc", pc, 32'h400);
    redirect_valid = 0;

    dbg_pc_we = 1; dbg_pc_wdata = 32'h1003; next();
    chk("dbgwr_pc", pc, 32'h1000);
    chk("dbgwr_cnt", 32'(adv_count), 32'd1);
    dbg_pc_we = 0; step_req = 1; next();
    chk("step_in", 32'(halted), 32'd0);
    chk("step_in_pc", pc, 32'h1000);
    step_req = 0; next();
    chk("step_pc", pc, 32'h1004);
    chk("step_halted", 32'(halted), 32'd1);
    step_req = 1; resume_req = 1; next();
    step_req = 0; resume_req = 0; next();
    chk("stepres_pc", pc, 32'h1008);
    chk("stepres_halted", 32'(halted), 32'd1);
    chk("stepres_cnt", 32'(adv_count), 32'd3);

    resume_req = 1; halt_req = 1; next();
    chk("res_blocked", 32'(halted), 32'd1);
    halt_req = 0; dbg_pc_we = 1; dbg_pc_wdata = 32'h2000; next();
    chk("resume_pc", pc, 32'h2000);
    chk("resume_fv", 32'(fetch_valid), 32'd1);
    resume_req = 0; dbg_pc_wdata = 32'h3000; step_req = 1; next();
    chk("run_dbg_ign", pc, 32'h2004);
    chk("run_cnt", 32'(adv_count), 32'd4);
    dbg_pc_we = 0; step_req = 0; stall = 1; next();
    chk("stall_fv", 32'(fetch_valid), 32'd0);

    stall = 0; halt_req = 1; next();
    chk("halt2_pc", pc, 32'h2008);
    halt_req = 0; step_req = 1; stall = 1; next();
    step_req = 0; next();
    chk("stepstall_pc", pc, 32'h2008);
    chk("stepstall_halted", 32'(halted), 32'd0);
    rst_n = 0; #1;
    chk("arst_pc", pc, 32'h80);
    chk("arst_cnt", 32'(adv_count), 32'd0);
    chk("arst_maddr", misalign_addr, 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    next();
    rst_n = 1; stall = 0; next();
    chk("post_rst_pc", pc, 32'h84);
    chk("post_rst_cnt", 32'(adv_count), 32'd1);
    next();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV core fetch stage: holds the architectural PC and advances it by a configurable step each unstalled cycle. It applies branch/jump redirects with alignment checking and gives the external debugger halt, resume, single-step and PC-write control. It also keeps a wrapping count of PC advances. Sits between the execute-stage redirect logic, the debug module and instruction-memory address generation.

## Interface
- XLEN, 32, PC and target width in bits
- STEP, 4, sequential increment added to PC
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- HALT_ON_RESET, 0, 1 = leave reset in HALTED, 0 = leave reset in RUN
- CNT_W, 32, width of advance counter

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  freezes PC advance in RUN and STEP
- redirect_valid  in  1  branch taken or jump this cycle
- redirect_target  in  XLEN  redirect destination
- halt_req  in  1  debugger halt request (level)
- resume_req  in  1  debugger resume request
- step_req  in  1  debugger single-step request
- dbg_pc_we  in  1  debugger PC write strobe, honoured only in HALTED
- dbg_pc_wdata  in  XLEN  debugger PC write data
- pc  out  XLEN  current PC (registered)
- pc_plus_step  out  XLEN  pc + STEP, combinational, modulo 2^XLEN
- fetch_valid  out  1  high when state != HALTED and stall = 0
- halted  out  1  high in HALTED
- misalign  out  1  one-cycle pulse on rejected misaligned redirect
- misalign_addr  out  XLEN  last rejected target, held until next rejection
- adv_count  out  CNT_W  number of PC updates since reset, wraps

## Operation
- Reset: pc = RESET_VECTOR; state = HALTED if HALT_ON_RESET else RUN; misalign = 0; misalign_addr = 0; adv_count = 0.
- Advance (RUN or STEP, stall = 0):
  - if redirect_valid and redirect_target[1:0] == 0, the next pc is redirect_target;
  - if redirect_valid and redirect_target[1:0] != 0, the next pc is pc_plus_step, misalign pulses and misalign_addr captures the target;
  - otherwise the next pc is pc_plus_step.
- Each advance increments adv_count by 1, modulo 2^CNT_W.
- Sum arithmetic: pc + STEP truncated to XLEN bits, so PC wraps from 2^XLEN - STEP to 0.
- Stall = 0 gates every advance. In RUN/STEP with stall = 1, pc, adv_count and state hold and redirects are ignored. The redirect source must hold the redirect until it is unstalled.
- States:
  - RUN: on an advance cycle with halt_req = 1, the advance completes and state becomes HALTED. With halt_req = 1 and stall = 1, the block stays in RUN until the first unstalled cycle.
  - HALTED: pc holds and no advance occurs. dbg_pc_we = 1 writes {dbg_pc_wdata[XLEN-1:2], 2'b00} to pc, and this write does not count as an advance. Then:
    - step_req = 1 moves the state to STEP;
    - else resume_req = 1 (with halt_req = 0) moves it to RUN;
    - resume_req with halt_req = 1 keeps it in HALTED.
    - A same-cycle dbg_pc_we is applied before the transition takes effect, i.e. both happen on the same edge.
  - STEP: performs exactly one advance, waiting out any stall cycles, then returns to HALTED on that same edge regardless of halt_req.
- Priority in HALTED: step_req > resume_req. resume_req and step_req are ignored outside HALTED. dbg_pc_we is ignored outside HALTED.

## Timing
- pc, halted, misalign and adv_count are registered and change only on the rising clk edge, except for asynchronous reset.
- Redirect latency: target visible on pc 1 cycle after the sampling edge.
- Halt latency: halted rises on the edge that completes the last advance. With stall low, halted is high 1 cycle after halt_req is sampled.
- Resume: fetch_valid high 1 cycle after the resume edge.
- Single step: with no stall, STEP lasts 1 cycle. halted falls 1 cycle after step_req and rises again 1 cycle later, and pc advances exactly once.
- An rst_n assertion at any point, including mid-STEP or mid-stall, immediately forces the reset values, with no pending request retained.

## Test plan
- Reset with RESET_VECTOR = 0x80, HALT_ON_RESET = 0, 3 unstalled cycles -> pc = 0x8C, adv_count = 3, halted = 0.
- pc = 0x100: redirect to 0x200 -> pc = 0x200 next cycle. Then redirect to 0x202 -> pc = 0x204, misalign pulses 1 cycle, misalign_addr = 0x202.
- pc = 0xFFFF_FFFC, XLEN = 32, STEP = 4, one advance -> pc = 0x0 and adv_count increments. Repeat with adv_count at its maximum value -> adv_count wraps to 0.
- halt_req while stall = 1 for 3 cycles -> pc and halted unchanged until stall drops. Then one advance happens and halted = 1.
- In HALTED: dbg_pc_we with data 0x1003 -> pc = 0x1000. step_req -> pc = 0x1004 and HALTED again. step_req + resume_req on the same cycle -> step taken only.
- rst_n low during STEP with stall = 1 -> pc = RESET_VECTOR, adv_count = 0, misalign = 0, and the state is the reset state.
